// File: rtl/data_read_ctrl_pkg.sv
// Shared definitions for the acquisition sequencer: state encodings, status bit
// positions and register map offsets used by the AXI-lite register blocks.
package data_read_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'h0,
        ST_ARM     = 2'h1,
        ST_CAPTURE = 2'h2,
        ST_DONE    = 2'h3
    } state_t;

    localparam int SR_BUSY_BIT    = 0;
    localparam int SR_DONE_BIT    = 1;
    localparam int SR_ABORTED_BIT = 2;
    localparam int SR_TIMEOUT_BIT = 3;

    localparam logic [7:0] REG_CR_ADDR      = 8'h00;
    localparam logic [7:0] REG_SR_ADDR      = 8'h04;
    localparam logic [7:0] REG_LEN_ADDR     = 8'h08;
    localparam logic [7:0] REG_TIMEOUT_ADDR = 8'h0C;
    localparam logic [7:0] REG_COUNT_ADDR   = 8'h10;

    // Packs the sticky/live flags into the SR register image.
    function automatic logic [3:0] pack_status(input logic busy, input logic done,
                                               input logic aborted, input logic timeout);
        logic [3:0] sr;
        sr                 = '0;
        sr[SR_BUSY_BIT]    = busy;
        sr[SR_DONE_BIT]    = done;
        sr[SR_ABORTED_BIT] = aborted;
        sr[SR_TIMEOUT_BIT] = timeout;
        return sr;
    endfunction

endpackage

// File: rtl/data_read_ctrl_if.sv
// Control, sample-stream, buffer-write and status bundle of the acquisition
// sequencer. The slave modport is the sequencer's view.
interface data_read_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic              cr_start;
    logic              cr_abort;
    logic [ADDR_W-1:0] cfg_len;
    logic [31:0]       cfg_timeout;
    logic              trigger;
    logic              sample_valid;
    logic [DATA_W-1:0] sample_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              sr_busy;
    logic              sr_done;
    logic              sr_aborted;
    logic              sr_timeout;
    logic [ADDR_W:0]   sr_count;
    logic              irq;

    modport master (
        output cr_start, cr_abort, cfg_len, cfg_timeout, trigger, sample_valid, sample_data,
        input  wr_en, wr_addr, wr_data, sr_busy, sr_done, sr_aborted, sr_timeout, sr_count, irq
    );

    modport slave (
        input  cr_start, cr_abort, cfg_len, cfg_timeout, trigger, sample_valid, sample_data,
        output wr_en, wr_addr, wr_data, sr_busy, sr_done, sr_aborted, sr_timeout, sr_count, irq
    );

endinterface

// File: rtl/data_read_ctrl_trig_timer.sv
// ARM-state trigger timeout counter; used only when DATA_READ_TRIG_TIMEOUT_EN
// is defined. expired is high during the limit-th consecutive ARM cycle.
module data_read_trig_timer
    import data_read_ctrl_pkg::*;
(
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESET,
    input  logic        clear,
    input  logic        run,
    input  logic [31:0] limit,
    output logic        expired
);

    logic [31:0] cnt_q;

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET || clear) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    // A zero limit disables the timeout entirely.
    assign expired = run && (limit != 32'd0) && (cnt_q == limit - 32'd1);

endmodule

// File: rtl/data_read_ctrl.sv
// Acquisition sequencer: start -> ARM -> trigger -> CAPTURE cfg_len samples -> DONE.
// Optional trigger timeout in ARM is built only with DATA_READ_TRIG_TIMEOUT_EN.
module data_read_ctrl
    import data_read_ctrl_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic            S_AXI_ACLK,
    input  logic            S_AXI_ARESET,
    data_read_ctrl_if.slave bus
);

    localparam logic [ADDR_W:0]   FULL_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   ONE_CNT  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ONE_ADDR = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic              start_hit, abort_hit, accept, last_smp;
    logic              timeout_hit, timeout_take, enter_done, in_arm;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   len_q, count_q;
    logic              done_q, aborted_q, irq_q;
    logic              wr_en_p1;
    logic [ADDR_W-1:0] wr_addr_p1;
    logic [DATA_W-1:0] wr_data_p1;

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) state_q <= ST_IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start_hit) state_d = ST_ARM;
            ST_ARM: begin
                if (abort_hit)        state_d = ST_IDLE;
                else if (bus.trigger) state_d = last_smp ? ST_DONE : ST_CAPTURE;
                else if (timeout_hit) state_d = ST_DONE;
            end
            ST_CAPTURE: begin
                if (abort_hit)     state_d = ST_IDLE;
                else if (last_smp) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Abort outranks every other event, including a start arriving with it.
    always_comb begin
        in_arm       = (state_q == ST_ARM);
        start_hit    = bus.cr_start && !bus.cr_abort &&
                       (state_q == ST_IDLE || state_q == ST_DONE);
        abort_hit    = bus.cr_abort && (state_q == ST_ARM || state_q == ST_CAPTURE);
        accept       = !abort_hit && bus.sample_valid &&
                       ((in_arm && bus.trigger) || state_q == ST_CAPTURE);
        last_smp     = accept && ((count_q + ONE_CNT) == len_q);
        timeout_take = in_arm && !abort_hit && !bus.trigger && timeout_hit;
        enter_done   = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    // Stage p1: accepted sample becomes a buffer write one cycle later.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            addr_q     <= '0;
            count_q    <= '0;
            len_q      <= '0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            irq_q      <= 1'b0;
            wr_en_p1   <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
        end else begin
            wr_en_p1 <= accept;
            irq_q    <= enter_done;
            if (start_hit) begin
                len_q     <= (bus.cfg_len == '0) ? FULL_LEN : {1'b0, bus.cfg_len};
                addr_q    <= '0;
                count_q   <= '0;
                done_q    <= 1'b0;
                aborted_q <= 1'b0;
            end else begin
                if (accept) begin
                    addr_q     <= addr_q + ONE_ADDR;
                    count_q    <= count_q + ONE_CNT;
                    wr_addr_p1 <= addr_q;
                    wr_data_p1 <= bus.sample_data;
                end
                if (abort_hit)  aborted_q <= 1'b1;
                if (enter_done) done_q    <= 1'b1;
            end
        end
    end

`ifdef DATA_READ_TRIG_TIMEOUT_EN
    logic timeout_q;

    data_read_trig_timer u_trig_timer (
        .S_AXI_ACLK   (S_AXI_ACLK),
        .S_AXI_ARESET (S_AXI_ARESET),
        .clear        (start_hit),
        .run          (in_arm),
        .limit        (bus.cfg_timeout),
        .expired      (timeout_hit)
    );

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET || start_hit) timeout_q <= 1'b0;
        else if (timeout_take)         timeout_q <= 1'b1;
    end

    assign bus.sr_timeout = timeout_q;
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^{bus.cfg_timeout, timeout_take};
    assign bus.sr_timeout = 1'b0;
`endif

    assign bus.wr_en      = wr_en_p1;
    assign bus.wr_addr    = wr_addr_p1;
    assign bus.wr_data    = wr_data_p1;
    assign bus.sr_busy    = (state_q == ST_ARM) || (state_q == ST_CAPTURE);
    assign bus.sr_done    = done_q;
    assign bus.sr_aborted = aborted_q;
    assign bus.sr_count   = count_q;
    assign bus.irq        = irq_q;

endmodule

// File: tb/tb_data_read_ctrl.sv
// Directed self-checking bench for data_read_ctrl (ADDR_W=4, DATA_W=16).
// The timeout scenario follows DATA_READ_TRIG_TIMEOUT_EN when it is defined.
module tb_data_read_ctrl;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    data_read_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    data_read_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] len);
        bus.cfg_len  = len;
        bus.cr_start = 1'b1;
        step();
        bus.cr_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.sr_busy, bus.sr_done, bus.sr_aborted,
             bus.sr_timeout, bus.sr_count, bus.irq} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got en=%b addr=%h data=%h busy=%b done=%b ab=%b to=%b cnt=%0d irq=%b required all 0",
                     bus.wr_en, bus.wr_addr, bus.wr_data, bus.sr_busy, bus.sr_done, bus.sr_aborted,
                     bus.sr_timeout, bus.sr_count, bus.irq);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int irqs = 0;
        do_start(4'd4);
        n_checks++;
        if (bus.sr_busy !== 1'b1) begin
            n_fail++; $display("FAIL basic_armed_busy: got %b required 1", bus.sr_busy);
        end
        bus.trigger      = 1'b1;
        bus.sample_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.sample_data = 16'(16'hA0 + i);
            step();
            bus.trigger = 1'b0;
            irqs += int'(bus.irq);
            n_checks++;
            if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b1, 4'(i), 16'(16'hA0 + i)}) begin
                n_fail++;
                $display("FAIL basic_write[%0d]: got en=%b addr=%0d data=%h required en=1 addr=%0d data=%h",
                         i, bus.wr_en, bus.wr_addr, bus.wr_data, i, 16'hA0 + i);
            end
        end
        n_checks++;
        if ({bus.sr_count, bus.sr_done, bus.sr_busy, bus.irq} !== {5'd4, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL basic_final: got cnt=%0d done=%b busy=%b irq=%b required cnt=4 done=1 busy=0 irq=1",
                     bus.sr_count, bus.sr_done, bus.sr_busy, bus.irq);
        end
        bus.sample_data = 16'hA4;
        step();
        irqs += int'(bus.irq);
        bus.sample_valid = 1'b0;
        n_checks++;
        if (bus.wr_en !== 1'b0 || irqs != 1) begin
            n_fail++;
            $display("FAIL basic_after_done: got wr_en=%b irqs=%0d required wr_en=0 irqs=1", bus.wr_en, irqs);
        end
    endtask

    task automatic test_full_depth();
        int irqs = 0;
        int bad  = 0;
        do_start(4'd0);
        bus.trigger      = 1'b1;
        bus.sample_valid = 1'b1;
        for (int i = 0; i < 18; i++) begin
            bus.sample_data = 16'(16'h100 + i);
            step();
            bus.trigger = 1'b0;
            irqs += int'(bus.irq);
            if (i < 16) begin
                if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b1, 4'(i), 16'(16'h100 + i)}) bad++;
            end else if (bus.wr_en !== 1'b0) begin
                bad++;
            end
        end
        bus.sample_valid = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL full_writes: got %0d bad write cycles required 0", bad);
        end
        n_checks++;
        if ({bus.sr_count, bus.sr_done, irqs == 1} !== {5'd16, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL full_final: got cnt=%0d done=%b irqs=%0d required cnt=16 done=1 irqs=1",
                     bus.sr_count, bus.sr_done, irqs);
        end
    endtask

    task automatic test_abort();
        int writes = 0;
        int irqs   = 0;
        do_start(4'd8);
        bus.trigger      = 1'b1;
        bus.sample_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.sample_data = 16'(16'h30 + i);
            step();
            bus.trigger = 1'b0;
            writes += int'(bus.wr_en);
        end
        bus.cr_abort    = 1'b1;
        bus.sample_data = 16'hEE;
        step();
        bus.cr_abort     = 1'b0;
        bus.sample_valid = 1'b0;
        writes += int'(bus.wr_en);
        irqs   += int'(bus.irq);
        n_checks++;
        if (writes != 3 || bus.sr_count !== 5'd3) begin
            n_fail++; $display("FAIL abort_writes: got writes=%0d cnt=%0d required 3 and 3", writes, bus.sr_count);
        end
        n_checks++;
        if ({bus.sr_aborted, bus.sr_done, bus.sr_busy} !== 3'b100 || irqs != 0) begin
            n_fail++;
            $display("FAIL abort_status: got ab=%b done=%b busy=%b irqs=%0d required ab=1 done=0 busy=0 irqs=0",
                     bus.sr_aborted, bus.sr_done, bus.sr_busy, irqs);
        end
        step();
        n_checks++;
        if (bus.irq !== 1'b0 || bus.wr_en !== 1'b0) begin
            n_fail++; $display("FAIL abort_quiet: got irq=%b wr_en=%b required 0 0", bus.irq, bus.wr_en);
        end
    endtask

    task automatic test_ignore_start();
        int stray = 0;
        bus.sample_valid = 1'b1;
        step();
        stray += int'(bus.wr_en);
        do_start(4'd3);
        stray += int'(bus.wr_en);
        step();
        stray += int'(bus.wr_en);
        n_checks++;
        if (stray != 0) begin
            n_fail++; $display("FAIL ignore_idle_arm_samples: got %0d writes required 0", stray);
        end
        bus.trigger     = 1'b1;
        bus.sample_data = 16'h0C0;
        step();
        bus.trigger      = 1'b0;
        bus.cfg_len      = 4'd6;
        bus.cr_start     = 1'b1;
        bus.sample_data  = 16'h0C1;
        step();
        bus.cr_start    = 1'b0;
        n_checks++;
        if ({bus.wr_en, bus.wr_addr, bus.sr_count} !== {1'b1, 4'd1, 5'd2}) begin
            n_fail++;
            $display("FAIL ignore_start_capture: got en=%b addr=%0d cnt=%0d required en=1 addr=1 cnt=2",
                     bus.wr_en, bus.wr_addr, bus.sr_count);
        end
        bus.sample_data = 16'h0C2;
        step();
        n_checks++;
        if ({bus.sr_count, bus.sr_done, bus.irq, bus.sr_busy} !== {5'd3, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL ignore_len_kept: got cnt=%0d done=%b irq=%b busy=%b required cnt=3 done=1 irq=1 busy=0",
                     bus.sr_count, bus.sr_done, bus.irq, bus.sr_busy);
        end
        step();
        bus.sample_valid = 1'b0;
        n_checks++;
        if (bus.wr_en !== 1'b0) begin
            n_fail++; $display("FAIL ignore_done_sample: got wr_en=%b required 0", bus.wr_en);
        end
        bus.cr_start = 1'b1;
        bus.cr_abort = 1'b1;
        step();
        bus.cr_start = 1'b0;
        bus.cr_abort = 1'b0;
        n_checks++;
        if ({bus.sr_done, bus.sr_busy, bus.sr_aborted, bus.sr_count} !== {1'b1, 1'b0, 1'b0, 5'd3}) begin
            n_fail++;
            $display("FAIL abort_beats_start: got done=%b busy=%b ab=%b cnt=%0d required done=1 busy=0 ab=0 cnt=3",
                     bus.sr_done, bus.sr_busy, bus.sr_aborted, bus.sr_count);
        end
    endtask

`ifdef DATA_READ_TRIG_TIMEOUT_EN
    task automatic test_timeout();
        bus.cfg_timeout = 32'd100;
        do_start(4'd2);
        for (int i = 0; i < 99; i++) step();
        n_checks++;
        if ({bus.sr_busy, bus.sr_timeout, bus.sr_done} !== 3'b100) begin
            n_fail++;
            $display("FAIL timeout_early: got busy=%b to=%b done=%b required 1 0 0",
                     bus.sr_busy, bus.sr_timeout, bus.sr_done);
        end
        step();
        n_checks++;
        if ({bus.sr_busy, bus.sr_timeout, bus.sr_done, bus.irq} !== 4'b0111) begin
            n_fail++;
            $display("FAIL timeout_fire: got busy=%b to=%b done=%b irq=%b required 0 1 1 1",
                     bus.sr_busy, bus.sr_timeout, bus.sr_done, bus.irq);
        end
        do_start(4'd2);
        for (int i = 0; i < 99; i++) step();
        bus.trigger      = 1'b1;
        bus.sample_valid = 1'b1;
        bus.sample_data  = 16'h55;
        step();
        bus.trigger = 1'b0;
        n_checks++;
        if ({bus.sr_busy, bus.sr_timeout, bus.irq, bus.wr_en, bus.wr_data} !== {4'b1001, 16'h55}) begin
            n_fail++;
            $display("FAIL timeout_trigger_wins: got busy=%b to=%b irq=%b en=%b data=%h required 1 0 0 1 0055",
                     bus.sr_busy, bus.sr_timeout, bus.irq, bus.wr_en, bus.wr_data);
        end
        bus.sample_data = 16'h56;
        step();
        bus.sample_valid = 1'b0;
        bus.cfg_timeout  = 32'd0;
        n_checks++;
        if ({bus.sr_done, bus.sr_timeout, bus.sr_count} !== {1'b1, 1'b0, 5'd2}) begin
            n_fail++;
            $display("FAIL timeout_run_done: got done=%b to=%b cnt=%0d required 1 0 2",
                     bus.sr_done, bus.sr_timeout, bus.sr_count);
        end
    endtask
`else
    task automatic test_timeout();
        bus.cfg_timeout = 32'd100;
        do_start(4'd2);
        for (int i = 0; i < 150; i++) step();
        n_checks++;
        if ({bus.sr_busy, bus.sr_timeout, bus.sr_done, bus.irq} !== 4'b1000) begin
            n_fail++;
            $display("FAIL timeout_disabled: got busy=%b to=%b done=%b irq=%b required 1 0 0 0",
                     bus.sr_busy, bus.sr_timeout, bus.sr_done, bus.irq);
        end
        bus.cr_abort = 1'b1;
        step();
        bus.cr_abort    = 1'b0;
        bus.cfg_timeout = 32'd0;
    endtask
`endif

    task automatic test_reset_mid_run();
        do_start(4'd5);
        bus.trigger      = 1'b1;
        bus.sample_valid = 1'b1;
        bus.sample_data  = 16'h11;
        step();
        bus.trigger = 1'b0;
        step();
        rst = 1'b1;
        step();
        n_checks++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.sr_busy, bus.sr_done, bus.sr_aborted,
             bus.sr_count, bus.irq} !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset: got en=%b addr=%0d data=%h busy=%b done=%b ab=%b cnt=%0d irq=%b required all 0",
                     bus.wr_en, bus.wr_addr, bus.wr_data, bus.sr_busy, bus.sr_done, bus.sr_aborted,
                     bus.sr_count, bus.irq);
        end
        rst              = 1'b0;
        bus.sample_valid = 1'b0;
        step();
        do_start(4'd2);
        bus.trigger      = 1'b1;
        bus.sample_valid = 1'b1;
        bus.sample_data  = 16'h77;
        step();
        bus.trigger = 1'b0;
        n_checks++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b1, 4'd0, 16'h77}) begin
            n_fail++;
            $display("FAIL rerun_first: got en=%b addr=%0d data=%h required 1 0 0077",
                     bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        bus.sample_data = 16'h78;
        step();
        bus.sample_valid = 1'b0;
        n_checks++;
        if ({bus.wr_addr, bus.wr_data, bus.sr_count, bus.sr_done, bus.irq} !== {4'd1, 16'h78, 5'd2, 2'b11}) begin
            n_fail++;
            $display("FAIL rerun_done: got addr=%0d data=%h cnt=%0d done=%b irq=%b required 1 0078 2 1 1",
                     bus.wr_addr, bus.wr_data, bus.sr_count, bus.sr_done, bus.irq);
        end
    endtask

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        rst              = 1'b1;
        bus.cr_start     = 1'b0;
        bus.cr_abort     = 1'b0;
        bus.cfg_len      = '0;
        bus.cfg_timeout  = 32'd0;
        bus.trigger      = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample_data  = '0;
        test_reset();
        test_basic();
        test_full_depth();
        test_abort();
        test_ignore_start();
        test_timeout();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
